// File: rtl/wb_arbiter_s.sv
// wb_arbiter_s: writeback sequencer merging ALU and load results onto one register-bank
// write port. Two small FIFOs (one per source), a round-robin arbiter that drains at most one
// entry per cycle into a registered write port, and a per-register pending bitmap.
// Optional build macro: WB_DROP_X0_EN -- accepted transfers to register 0 are discarded
// instead of buffered.
module wb_arbiter_s #(
    parameter int unsigned DIR_WIDTH  = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [DIR_WIDTH-1:0]    alu_dir,
    input  logic [DATA_WIDTH-1:0]   alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [DIR_WIDTH-1:0]    mem_dir,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    output logic                    write_en,
    output logic [DIR_WIDTH-1:0]    write_dir,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic [2**DIR_WIDTH-1:0] pending
);

    localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    // Index 0 is the ALU source, index 1 is the MEM source.
    typedef enum logic {
        GntAlu = 1'b0,
        GntMem = 1'b1
    } grant_e;

    // Per-source FIFO state
    logic [DIR_WIDTH-1:0]  dir_q  [2][BUF_DEPTH];
    logic [DATA_WIDTH-1:0] data_q [2][BUF_DEPTH];
    logic [PtrW-1:0]       wptr_q [2];
    logic [PtrW-1:0]       wptr_d [2];
    logic [PtrW-1:0]       rptr_q [2];
    logic [PtrW-1:0]       rptr_d [2];
    logic [CntW-1:0]       cnt_q  [2];
    logic [CntW-1:0]       cnt_d  [2];

    // Source-indexed views of the input ports
    logic                  in_valid [2];
    logic [DIR_WIDTH-1:0]  in_dir   [2];
    logic [DATA_WIDTH-1:0] in_data  [2];
    logic [1:0]            ready;
    logic [1:0]            push;
    logic [1:0]            grant;

    grant_e                last_q;
    logic                  write_en_q;
    logic [DIR_WIDTH-1:0]  write_dir_q;
    logic [DATA_WIDTH-1:0] write_data_q;
    logic [DIR_WIDTH-1:0]  head_dir;
    logic [DATA_WIDTH-1:0] head_data;
    logic [2**DIR_WIDTH-1:0] pending_d;

    assign in_valid[0] = alu_valid;
    assign in_dir[0]   = alu_dir;
    assign in_data[0]  = alu_data;
    assign in_valid[1] = mem_valid;
    assign in_dir[1]   = mem_dir;
    assign in_data[1]  = mem_data;

    // Ready depends only on the registered count: a full FIFO stalls even if popped this cycle.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            ready[s] = (cnt_q[s] != CntW'(BUF_DEPTH));
`ifdef WB_DROP_X0_EN
            push[s]  = in_valid[s] && ready[s] && (in_dir[s] != '0);
`else
            push[s]  = in_valid[s] && ready[s];
`endif
        end
    end

    assign alu_ready = ready[0];
    assign mem_ready = ready[1];

    // Round-robin arbiter: on a tie, grant whichever source did not win last time.
    always_comb begin
        grant    = 2'b00;
        grant[0] = (cnt_q[0] != '0) && ((cnt_q[1] == '0) || (last_q == GntMem));
        grant[1] = (cnt_q[1] != '0) && !grant[0];
    end

    // Head of the granted FIFO
    always_comb begin
        if (grant[0]) begin
            head_dir  = dir_q[0][rptr_q[0]];
            head_data = data_q[0][rptr_q[0]];
        end else begin
            head_dir  = dir_q[1][rptr_q[1]];
            head_data = data_q[1][rptr_q[1]];
        end
    end

    // FIFO pointer and count next-state; a pop is exactly a grant.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            wptr_d[s] = push[s]  ? wptr_q[s] + PtrW'(1) : wptr_q[s];
            rptr_d[s] = grant[s] ? rptr_q[s] + PtrW'(1) : rptr_q[s];
            cnt_d[s]  = cnt_q[s] + CntW'(push[s]) - CntW'(grant[s]);
        end
    end

    // FIFO pointers and counts; reset empties both FIFOs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int s = 0; s < 2; s++) begin
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
                cnt_q[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                wptr_q[s] <= wptr_d[s];
                rptr_q[s] <= rptr_d[s];
                cnt_q[s]  <= cnt_d[s];
            end
        end
    end

    // FIFO storage; contents are qualified by the count so no reset is needed.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                dir_q[s][wptr_q[s]]  <= in_dir[s];
                data_q[s][wptr_q[s]] <= in_data[s];
            end
        end
    end

    // Registered write port and last-grant tracking; dir/data hold when nothing is granted.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            write_en_q   <= 1'b0;
            write_dir_q  <= '0;
            write_data_q <= '0;
            last_q       <= GntMem;
        end else begin
            write_en_q <= |grant;
            if (|grant) begin
                write_dir_q  <= head_dir;
                write_data_q <= head_data;
                last_q       <= grant[0] ? GntAlu : GntMem;
            end
        end
    end

    assign write_en   = write_en_q;
    assign write_dir  = write_dir_q;
    assign write_data = write_data_q;

    // Pending bitmap: every live FIFO slot of both sources plus the write port itself.
    always_comb begin
        pending_d = '0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                // Slot i is live when its distance from the read pointer is below the count.
                if (CntW'(PtrW'(PtrW'(i) - rptr_q[s])) < cnt_q[s]) begin
                    pending_d[dir_q[s][i]] = 1'b1;
                end
            end
        end
        if (write_en_q) begin
            pending_d[write_dir_q] = 1'b1;
        end
        // Register 0 is hardwired, so a write to it never creates a hazard.
        pending_d[0] = 1'b0;
    end

    assign pending = pending_d;

endmodule

// File: tb/tb_wb_arbiter_s.sv
// tb_wb_arbiter_s: directed vector table for single/dual-source writes, WAW ordering and
// register-0 handling, plus hand-written sequences for sustained traffic and async reset.
module tb_wb_arbiter_s;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_dir = '0;
    logic [31:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_dir = '0;
    logic [31:0] mem_data = '0;
    logic        write_en;
    logic [4:0]  write_dir;
    logic [31:0] write_data;
    logic [31:0] pending;

    int n_vec  = 0;
    int n_fail = 0;

    wb_arbiter_s #(
        .DIR_WIDTH (5),
        .DATA_WIDTH(32),
        .BUF_DEPTH (2)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_dir   (alu_dir),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_dir   (mem_dir),
        .mem_data  (mem_data),
        .write_en  (write_en),
        .write_dir (write_dir),
        .write_data(write_data),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ad;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  md;
        logic [31:0] mdat;
        logic        e_we;
        logic [4:0]  e_dir;
        logic [31:0] e_data;
        logic [31:0] e_pend;
    } vec_t;

    localparam int NVec = 19;
    vec_t vecs [NVec];

    function automatic vec_t mk(input logic av, input logic [4:0] ad, input logic [31:0] adat,
                                input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                                input logic e_we, input logic [4:0] e_dir,
                                input logic [31:0] e_data, input logic [31:0] e_pend);
        vec_t v;
        v.av = av; v.ad = ad; v.adat = adat;
        v.mv = mv; v.md = md; v.mdat = mdat;
        v.e_we = e_we; v.e_dir = e_dir; v.e_data = e_data; v.e_pend = e_pend;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the sustained-traffic sequence; data[31:28] tags the source.
    logic [31:0] exp_a [$];
    logic [31:0] exp_m [$];
    int          prev_src = -1;

    task automatic sb_check(input bit check_alt);
        logic [31:0] e;
        int          src;
        if (write_en) begin
            src = (write_data[31:28] == 4'hA) ? 0 : 1;
            if (src == 0) begin
                check("sb alu data present", 32'(exp_a.size() != 0), 32'd1);
                if (exp_a.size() != 0) begin
                    e = exp_a.pop_front();
                    check("sb alu data", write_data, e);
                    check("sb alu dir", 32'(write_dir), 32'(1 + e[15:0] % 15));
                end
            end else begin
                check("sb mem tag", 32'(write_data[31:28]), 32'hB);
                check("sb mem data present", 32'(exp_m.size() != 0), 32'd1);
                if (exp_m.size() != 0) begin
                    e = exp_m.pop_front();
                    check("sb mem data", write_data, e);
                    check("sb mem dir", 32'(write_dir), 32'(16 + e[15:0] % 15));
                end
            end
            if (check_alt && prev_src != -1) begin
                check("stream alternation", 32'(src != prev_src), 32'd1);
            end
            prev_src = src;
        end
    endtask

    initial begin
        bit acc_a, acc_m, a_low, m_low;
        int sa, sm;

        // Test 2 (first tie after reset goes to ALU)
        vecs[0]  = mk(0, 0, 0, 0, 0, 0,                 0, 0, 32'h0, 32'h0);
        vecs[1]  = mk(1, 1, 32'h11, 1, 2, 32'h22,       0, 0, 32'h0, 32'h0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0,                 0, 0, 32'h0, 32'h6);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0,                 1, 1, 32'h11, 32'h6);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0,                 1, 2, 32'h22, 32'h4);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0,                 0, 2, 32'h22, 32'h0);
        // Test 1: single ALU write
        vecs[6]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,      0, 2, 32'h22, 32'h0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0,                 0, 2, 32'h22, 32'h20);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0,                 1, 5, 32'hDEADBEEF, 32'h20);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0,                 0, 5, 32'hDEADBEEF, 32'h0);
        // Test 4: back-to-back writes to the same register
        vecs[10] = mk(1, 3, 32'hA, 0, 0, 0,             0, 5, 32'hDEADBEEF, 32'h0);
        vecs[11] = mk(1, 3, 32'hB, 0, 0, 0,             0, 5, 32'hDEADBEEF, 32'h8);
        vecs[12] = mk(0, 0, 0, 0, 0, 0,                 1, 3, 32'hA, 32'h8);
        vecs[13] = mk(0, 0, 0, 0, 0, 0,                 1, 3, 32'hB, 32'h8);
        vecs[14] = mk(0, 0, 0, 0, 0, 0,                 0, 3, 32'hB, 32'h0);
        // Test 6: MEM write to register 0
        vecs[15] = mk(0, 0, 0, 1, 0, 32'h55,            0, 3, 32'hB, 32'h0);
        vecs[16] = mk(0, 0, 0, 0, 0, 0,                 0, 3, 32'hB, 32'h0);
`ifdef WB_DROP_X0_EN
        vecs[17] = mk(0, 0, 0, 0, 0, 0,                 0, 3, 32'hB, 32'h0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0,                 0, 3, 32'hB, 32'h0);
`else
        vecs[17] = mk(0, 0, 0, 0, 0, 0,                 1, 0, 32'h55, 32'h0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0,                 0, 0, 32'h55, 32'h0);
`endif

        #12;
        arst_n = 1'b1;
        step();

        for (int k = 0; k < NVec; k++) begin
            alu_valid = vecs[k].av; alu_dir = vecs[k].ad; alu_data = vecs[k].adat;
            mem_valid = vecs[k].mv; mem_dir = vecs[k].md; mem_data = vecs[k].mdat;
            check($sformatf("vec[%0d] write_en", k), 32'(write_en), 32'(vecs[k].e_we));
            check($sformatf("vec[%0d] write_dir", k), 32'(write_dir), 32'(vecs[k].e_dir));
            check($sformatf("vec[%0d] write_data", k), write_data, vecs[k].e_data);
            check($sformatf("vec[%0d] pending", k), pending, vecs[k].e_pend);
            check($sformatf("vec[%0d] alu_ready", k), 32'(alu_ready), 32'd1);
            check($sformatf("vec[%0d] mem_ready", k), 32'(mem_ready), 32'd1);
            step();
        end

        // Test 3: both sources valid every cycle for 20 cycles
        sa = 0; sm = 0; a_low = 0; m_low = 0;
        for (int c = 0; c < 20; c++) begin
            sb_check(c >= 3);
            if (c >= 2) check($sformatf("stream c%0d write_en", c), 32'(write_en), 32'd1);
            alu_valid = 1'b1; alu_dir = 5'(1 + sa % 15); alu_data = 32'hA000_0000 | 32'(sa);
            mem_valid = 1'b1; mem_dir = 5'(16 + sm % 15); mem_data = 32'hB000_0000 | 32'(sm);
            acc_a = alu_ready; acc_m = mem_ready;
            if (!alu_ready) a_low = 1'b1;
            if (!mem_ready) m_low = 1'b1;
            step();
            if (acc_a) begin exp_a.push_back(32'hA000_0000 | 32'(sa)); sa++; end
            if (acc_m) begin exp_m.push_back(32'hB000_0000 | 32'(sm)); sm++; end
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            sb_check(1'b0);
            step();
        end
        check("stream alu drained", 32'(exp_a.size()), 32'd0);
        check("stream mem drained", 32'(exp_m.size()), 32'd0);
        check("stream alu_ready went low", 32'(a_low), 32'd1);
        check("stream mem_ready went low", 32'(m_low), 32'd1);
        check("stream idle write_en", 32'(write_en), 32'd0);
        check("stream idle pending", pending, 32'h0);

        // Test 5: async reset with entries in flight (reset first so ALU wins the tie)
        arst_n = 1'b0; #2; arst_n = 1'b1;
        step();
        alu_valid = 1; alu_dir = 7;  alu_data = 32'h70;
        mem_valid = 1; mem_dir = 8;  mem_data = 32'h80;
        step();
        alu_dir = 9;  alu_data = 32'h90;
        mem_dir = 10; mem_data = 32'hA0;
        step();
        alu_dir = 11; alu_data = 32'hB0;
        mem_valid = 0;
        step();
        alu_valid = 0;
        check("rst pre write_en", 32'(write_en), 32'd1);
        check("rst pre write_dir", 32'(write_dir), 32'd8);
        check("rst pre write_data", write_data, 32'h80);
        check("rst pre alu_ready", 32'(alu_ready), 32'd0);
        check("rst pre pending", pending, 32'hF00);
        #2;
        arst_n = 1'b0;
        #1;
        check("rst write_en", 32'(write_en), 32'd0);
        check("rst write_dir", 32'(write_dir), 32'd0);
        check("rst write_data", write_data, 32'h0);
        check("rst pending", pending, 32'h0);
        check("rst alu_ready", 32'(alu_ready), 32'd1);
        check("rst mem_ready", 32'(mem_ready), 32'd1);
        #1;
        arst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("post-rst c%0d write_en", c), 32'(write_en), 32'd0);
            check($sformatf("post-rst c%0d pending", c), pending, 32'h0);
            check($sformatf("post-rst c%0d readies", c), 32'({alu_ready, mem_ready}), 32'd3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_s.md
Name: wb_arbiter_s

Overview:
Writeback sequencer that merges result streams from the ALU and the memory/load unit onto the single write port of the register bank (write_en/write_dir/write_data). Each source has a small FIFO with a valid/ready handshake. A round-robin arbiter drains at most one entry per cycle into a registered write port. A per-register pending bitmap tells decode/hazard logic which destinations still have an outstanding write.

Parameters:
DIR_WIDTH, 5, register address width; the bank has 2**DIR_WIDTH registers.
DATA_WIDTH, 32, register data width.
BUF_DEPTH, 2, entries per source FIFO; must be a power of two and at least 2.

Ports:
clk  input  1  clock, rising edge.
arst_n  input  1  asynchronous active-low reset.
alu_valid  input  1  ALU result valid.
alu_ready  output  1  ALU FIFO can accept.
alu_dir  input  DIR_WIDTH  ALU destination register.
alu_data  input  DATA_WIDTH  ALU result.
mem_valid  input  1  load result valid.
mem_ready  output  1  load FIFO can accept.
mem_dir  input  DIR_WIDTH  load destination register.
mem_data  input  DATA_WIDTH  load result.
write_en  output  1  to the bank's write_en.
write_dir  output  DIR_WIDTH  to the bank's write_dir.
write_data  output  DATA_WIDTH  to the bank's write_data.
pending  output  2**DIR_WIDTH  bit d is high while any write to register d is buffered or on the port.

Behaviour:
- Reset (arst_n low, asynchronous):
  - Both FIFOs are emptied.
  - write_en, write_dir and write_data go to 0.
  - pending goes to all zeros.
  - last_grant goes to MEM, so ALU wins the first tie.
  - Anything in flight at reset is discarded and is never written after release.
- Accept: a transfer happens at a rising edge when x_valid and x_ready are both high.
  - x_ready = (count_x != BUF_DEPTH), decoded from registered count only. It has no combinational dependence on valid or on a same-cycle pop.
  - A full FIFO therefore stalls for one cycle even if it is popped that cycle.
  - If x_valid is high while x_ready is low, the input is not taken. The source must hold dir/data stable until the transfer completes.
- FIFO: each FIFO uses a circular read/write pointer pair of log2(BUF_DEPTH) bits, wrapping modulo BUF_DEPTH, plus a count of log2(BUF_DEPTH)+1 bits. Order within a source is strict FIFO. Push and pop in the same cycle leave the count unchanged.
- Arbitration, evaluated each cycle:
  - Only ALU non-empty: grant ALU.
  - Only MEM non-empty: grant MEM.
  - Both non-empty: grant the source that is not last_grant.
  - last_grant updates on every grant.
  - Neither non-empty: no grant, and write_en is 0 next cycle.
- Output register: on a grant, the FIFO head is popped and write_en=1, write_dir and write_data load at the same edge. With no grant, write_en is loaded 0 and dir/data hold their values.
- Latency: valid+ready in cycle C0 → entry sits in the FIFO during C1 → write_en high during C2 → the bank captures at the end of C2. Sustained throughput is one write per cycle in total.
- A newly accepted entry cannot be granted in the cycle it is accepted; there is no bypass.
- pending[d], combinational from state: OR over all valid FIFO entries of both sources plus (write_en && write_dir==d). pending[0] is always 0. Multiple outstanding writes to the same d keep the bit high until the last one leaves the port.
- Cross-source ordering is defined only by the arbiter. Producers must not issue WAW to the same register from both sources while pending[d] is high.

Optional Feature:
WB_DROP_X0_EN
- Defined: an input transfer with dir==0 is still accepted (ready semantics unchanged) but is not pushed, so it never occupies a slot, never appears on the port and never sets pending.
- Undefined: a dir==0 transfer is buffered and arbitrated like any other and appears on the port with write_en=1, where the bank ignores it.

Test Plan:
1. ALU single write, dir=5, data=0xDEADBEEF in C0 → write_en=1, write_dir=5, write_data=0xDEADBEEF in C2 only. pending[5] is high in C1–C2 and low in C3.
2. ALU (dir=1, 0x11) and MEM (dir=2, 0x22) both valid in C0 → C2 writes dir 1 / 0x11, C3 writes dir 2 / 0x22, C4 has write_en=0.
3. Both sources valid every cycle for 20 cycles, BUF_DEPTH=2 → writes alternate ALU/MEM and write_en stays high every cycle once the pipe fills. Each ready goes low at least once, and the scoreboard shows no lost or duplicated data and per-source order preserved.
4. ALU pushes dir=3 0xA, then dir=3 0xB → the bank sees 0xA, then 0xB. pending[3] stays high continuously until the cycle after 0xB is on the port.
5. Two entries buffered in ALU and write_en=1, then arst_n pulsed low mid-cycle → write_en, pending and the outputs are 0 immediately. After release both readies are high and no stale write ever appears.
6. MEM writes dir=0, data 0x55 → with WB_DROP_X0_EN there is no write_en pulse; without it, write_en=1 with dir=0 in C2. pending[0] is 0 in both builds.
